// File: rtl/npc_pkg.sv
// Shared types and constants for the fetch-stage next-PC unit.
// Used by npc_cond and npc_fetch; NPC_STATS_EN adds branch statistics counters to npc_fetch.
package npc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned IDX_W = 26;
    localparam int unsigned OP_W  = 4;

    typedef logic [XLEN-1:0] pc_t;

    localparam pc_t PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [OP_W-1:0] {
        NONE = 4'd0,
        BEQ  = 4'd1,
        BNE  = 4'd2,
        BGEZ = 4'd3,
        BGTZ = 4'd4,
        BLEZ = 4'd5,
        BLTZ = 4'd6,
        J    = 4'd7,
        JAL  = 4'd8,
        JR   = 4'd9,
        JALR = 4'd10
    } br_op_t;

    // ID-stage comparator flags as one bundle
    typedef struct packed {
        logic zero;
        logic isge;
        logic isgreat;
    } cmp_flags_t;

    function automatic logic is_cond_branch(input logic [OP_W-1:0] op);
        return (op >= OP_W'(BEQ)) && (op <= OP_W'(BLTZ));
    endfunction

endpackage

// File: rtl/npc_cond.sv
// Combinational branch/jump resolution: taken flag and control-transfer target.
module npc_cond
    import npc_pkg::*;
(
    input  logic [OP_W-1:0]  br_op,
    input  cmp_flags_t       flags,
    input  pc_t              pc_id,
    input  logic [IMM_W-1:0] imm16,
    input  logic [IDX_W-1:0] index26,
    input  pc_t              rs_val,
    output logic             taken,
    output pc_t              target
);

    pc_t pc_plus4;
    pc_t br_tgt;
    pc_t jmp_tgt;

    assign pc_plus4 = pc_id + 32'd4;
    assign br_tgt   = pc_plus4 + {{14{imm16[IMM_W-1]}}, imm16, 2'b00};
    assign jmp_tgt  = {pc_plus4[31:28], index26, 2'b00};

    // Undefined op codes fall through like NONE
    always_comb begin
        taken  = 1'b0;
        target = br_tgt;
        case (br_op)
            BEQ:       taken = flags.zero;
            BNE:       taken = !flags.zero;
            BGEZ:      taken = flags.isge;
            BGTZ:      taken = flags.isgreat;
            BLEZ:      taken = !flags.isgreat;
            BLTZ:      taken = !flags.isge;
            J, JAL: begin
                taken  = 1'b1;
                target = jmp_tgt;
            end
            JR, JALR: begin
                taken  = 1'b1;
                target = rs_val;
            end
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/npc_fetch.sv
// Fetch-stage PC register and IF/ID pipeline register with one delay slot.
// Optional NPC_STATS_EN adds conditional-branch and taken-branch counters.
module npc_fetch
    import npc_pkg::*;
#(
    parameter pc_t PC_RESET = PC_RESET_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [XLEN-1:0]  instr_if,
    input  logic [OP_W-1:0]  br_op,
    input  logic [IMM_W-1:0] imm16,
    input  logic [IDX_W-1:0] index26,
    input  logic [XLEN-1:0]  rs_val,
    input  logic             zero,
    input  logic             isge,
    input  logic             isgreat,
    output logic [XLEN-1:0]  pc_if,
    output logic [XLEN-1:0]  instr_id,
    output logic [XLEN-1:0]  pc_id,
    output logic [XLEN-1:0]  pc8_id,
    output logic             taken_id
`ifdef NPC_STATS_EN
    ,
    output logic [XLEN-1:0]  br_cnt,
    output logic [XLEN-1:0]  taken_cnt
`endif
);

    pc_t        pc_q, pc_d;
    pc_t        pc_id_q, pc_id_d;
    logic [XLEN-1:0] instr_q, instr_d;
    pc_t        target;
    cmp_flags_t flags;

    assign flags = '{zero: zero, isge: isge, isgreat: isgreat};

    npc_cond u_cond (
        .br_op   (br_op),
        .flags   (flags),
        .pc_id   (pc_id_q),
        .imm16   (imm16),
        .index26 (index26),
        .rs_val  (rs_val),
        .taken   (taken_id),
        .target  (target)
    );

    // Stall freezes fetch and IF/ID; the delay slot is never flushed
    always_comb begin
        pc_d    = pc_q;
        pc_id_d = pc_id_q;
        instr_d = instr_q;
        if (!stall) begin
            pc_d    = taken_id ? target : pc_q + 32'd4;
            pc_id_d = pc_q;
            instr_d = instr_if;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            pc_id_q <= PC_RESET;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            pc_id_q <= pc_id_d;
            instr_q <= instr_d;
        end
    end

    assign pc_if    = pc_q;
    assign pc_id    = pc_id_q;
    assign instr_id = instr_q;
    assign pc8_id   = pc_id_q + 32'd8;

`ifdef NPC_STATS_EN
    logic [XLEN-1:0] br_cnt_q, br_cnt_d;
    logic [XLEN-1:0] taken_cnt_q, taken_cnt_d;

    // Only conditional branches on advancing edges are counted
    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (!stall && is_cond_branch(br_op)) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (taken_id) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_npc_fetch.sv
// Bench for npc_fetch: directed vector table plus randomized run against a reference model.
module tb_npc_fetch;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] instr_if;
    logic [3:0]  br_op;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] rs_val;
    logic        zero, isge, isgreat;
    logic [31:0] pc_if, instr_id, pc_id, pc8_id;
    logic        taken_id;
`ifdef NPC_STATS_EN
    logic [31:0] br_cnt, taken_cnt;
`endif

    always #5 clk = ~clk;

    npc_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .instr_if (instr_if),
        .br_op    (br_op),
        .imm16    (imm16),
        .index26  (index26),
        .rs_val   (rs_val),
        .zero     (zero),
        .isge     (isge),
        .isgreat  (isgreat),
        .pc_if    (pc_if),
        .instr_id (instr_id),
        .pc_id    (pc_id),
        .pc8_id   (pc8_id),
        .taken_id (taken_id)
`ifdef NPC_STATS_EN
        ,
        .br_cnt   (br_cnt),
        .taken_cnt(taken_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic [3:0]  op;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic        z, ge, gt;
        logic [31:0] instr;
        logic        exp_taken;
        logic [31:0] exp_pc, exp_pcid, exp_instr;
    } vec_t;

    vec_t tbl[21];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic stl, input logic [3:0] op,
                                input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                                input logic z, input logic ge, input logic gt, input logic [31:0] instr,
                                input logic et, input logic [31:0] epc, input logic [31:0] epcid,
                                input logic [31:0] einstr);
        vec_t v;
        v.rst = rst; v.stl = stl; v.op = op; v.imm = imm; v.idx = idx; v.rs = rs;
        v.z = z; v.ge = ge; v.gt = gt; v.instr = instr;
        v.exp_taken = et; v.exp_pc = epc; v.exp_pcid = epcid; v.exp_instr = einstr;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic stl, input logic [3:0] op, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs, input logic z, input logic ge,
                         input logic gt, input logic [31:0] instr);
        reset = rst; stall = stl; br_op = op; imm16 = imm; index26 = idx; rs_val = rs;
        zero = z; isge = ge; isgreat = gt; instr_if = instr;
    endtask

    // Reference: control-flow rules evaluated arithmetically
    function automatic void ref_eval(input logic [3:0] op, input logic [15:0] imm, input logic [25:0] idx,
                                     input logic [31:0] rs, input logic z, input logic ge, input logic gt,
                                     input logic [31:0] pcid, output logic tk, output logic [31:0] tgt);
        int off;
        off = int'($signed(imm)) * 4;
        tk  = 1'b0;
        tgt = 32'h0;
        case (op)
            4'd1: begin tk = z;   tgt = pcid + 32'd4 + 32'(off); end
            4'd2: begin tk = !z;  tgt = pcid + 32'd4 + 32'(off); end
            4'd3: begin tk = ge;  tgt = pcid + 32'd4 + 32'(off); end
            4'd4: begin tk = gt;  tgt = pcid + 32'd4 + 32'(off); end
            4'd5: begin tk = !gt; tgt = pcid + 32'd4 + 32'(off); end
            4'd6: begin tk = !ge; tgt = pcid + 32'd4 + 32'(off); end
            4'd7, 4'd8: begin tk = 1'b1; tgt = ((pcid + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4); end
            4'd9, 4'd10: begin tk = 1'b1; tgt = rs; end
            default: tk = 1'b0;
        endcase
    endfunction

    initial begin
        logic [31:0] m_pc, m_pcid, m_instr, m_br, m_tk, tgt;
        logic        tk;
        logic        rst, stl, z, ge, gt;
        logic [3:0]  op;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs, ins;

        tbl[0]  = mk(1,1,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'hAAAA_AAAA, 0, 32'h3000,     32'h3000,     32'h0);
        tbl[1]  = mk(1,1,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'hAAAA_AAAA, 0, 32'h3000,     32'h3000,     32'h0);
        tbl[2]  = mk(0,0,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'h1111_1111, 0, 32'h3004,     32'h3000,     32'h1111_1111);
        tbl[3]  = mk(0,0,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'h2222_2222, 0, 32'h3008,     32'h3004,     32'h2222_2222);
        tbl[4]  = mk(0,0,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'h3333_3333, 0, 32'h300C,     32'h3008,     32'h3333_3333);
        tbl[5]  = mk(0,0,BEQ,  16'hFFFE,26'h0,     32'h0,        1,0,0, 32'h4444_4444, 1, 32'h3004,     32'h300C,     32'h4444_4444);
        tbl[6]  = mk(0,0,BLTZ, 16'h0,   26'h0,     32'h0,        0,1,0, 32'h5555_5555, 0, 32'h3008,     32'h3004,     32'h5555_5555);
        tbl[7]  = mk(0,0,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'h6666_6666, 0, 32'h300C,     32'h3008,     32'h6666_6666);
        tbl[8]  = mk(0,0,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'h7777_7777, 0, 32'h3010,     32'h300C,     32'h7777_7777);
        tbl[9]  = mk(0,0,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'h8888_8888, 0, 32'h3014,     32'h3010,     32'h8888_8888);
        tbl[10] = mk(0,0,JAL,  16'h0,   26'h0C40,  32'h0,        0,0,0, 32'h9999_9999, 1, 32'h3100,     32'h3014,     32'h9999_9999);
        tbl[11] = mk(0,0,JR,   16'h0,   26'h0,     32'h3020,     0,0,0, 32'hA0A0_A0A0, 1, 32'h3020,     32'h3100,     32'hA0A0_A0A0);
        tbl[12] = mk(0,1,BNE,  16'h0010,26'h0,     32'h0,        1,0,0, 32'hB1B1_B1B1, 0, 32'h3020,     32'h3100,     32'hA0A0_A0A0);
        tbl[13] = mk(0,1,BNE,  16'h0010,26'h0,     32'h0,        0,0,0, 32'hB2B2_B2B2, 1, 32'h3020,     32'h3100,     32'hA0A0_A0A0);
        tbl[14] = mk(0,1,BNE,  16'h0010,26'h0,     32'h0,        0,0,0, 32'hB3B3_B3B3, 1, 32'h3020,     32'h3100,     32'hA0A0_A0A0);
        tbl[15] = mk(0,0,BNE,  16'h0010,26'h0,     32'h0,        0,0,0, 32'hB4B4_B4B4, 1, 32'h3144,     32'h3020,     32'hB4B4_B4B4);
        tbl[16] = mk(0,0,JR,   16'h0,   26'h0,     32'hFFFF_FFF8,0,0,0, 32'hC1C1_C1C1, 1, 32'hFFFF_FFF8,32'h3144,     32'hC1C1_C1C1);
        tbl[17] = mk(0,0,NONE, 16'h0,   26'h0,     32'h0,        0,0,0, 32'hC2C2_C2C2, 0, 32'hFFFF_FFFC,32'hFFFF_FFF8,32'hC2C2_C2C2);
        tbl[18] = mk(0,0,BEQ,  16'h0001,26'h0,     32'h0,        1,0,0, 32'hC3C3_C3C3, 1, 32'h0000_0000,32'hFFFF_FFFC,32'hC3C3_C3C3);
        tbl[19] = mk(0,0,4'hF, 16'h0,   26'h0,     32'h0,        1,1,1, 32'hC4C4_C4C4, 0, 32'h0000_0004,32'h0000_0000,32'hC4C4_C4C4);
        tbl[20] = mk(1,0,BEQ,  16'h0,   26'h0,     32'h0,        1,0,0, 32'hC5C5_C5C5, 1, 32'h3000,     32'h3000,     32'h0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].op, tbl[i].imm, tbl[i].idx, tbl[i].rs,
                  tbl[i].z, tbl[i].ge, tbl[i].gt, tbl[i].instr);
            #1;
            chk($sformatf("vec%0d taken_id", i), 32'(taken_id), 32'(tbl[i].exp_taken));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d pc_if", i),    pc_if,    tbl[i].exp_pc);
            chk($sformatf("vec%0d pc_id", i),    pc_id,    tbl[i].exp_pcid);
            chk($sformatf("vec%0d instr_id", i), instr_id, tbl[i].exp_instr);
            chk($sformatf("vec%0d pc8_id", i),   pc8_id,   tbl[i].exp_pcid + 32'd8);
`ifdef NPC_STATS_EN
            if (i == 15) begin
                chk("stats br_cnt", br_cnt, 32'd3);
                chk("stats taken_cnt", taken_cnt, 32'd2);
            end
            if (i == 20) begin
                chk("stats br_cnt reset", br_cnt, 32'd0);
                chk("stats taken_cnt reset", taken_cnt, 32'd0);
            end
`endif
        end

        m_pc = 32'h3000; m_pcid = 32'h3000; m_instr = 32'h0; m_br = 32'h0; m_tk = 32'h0;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            stl = ($urandom_range(0, 3) == 0);
            op  = 4'($urandom_range(0, 15));
            imm = 16'($urandom);
            idx = 26'($urandom);
            rs  = $urandom;
            z   = 1'($urandom); ge = 1'($urandom); gt = 1'($urandom);
            ins = $urandom;
            drive(rst, stl, op, imm, idx, rs, z, ge, gt, ins);
            ref_eval(op, imm, idx, rs, z, ge, gt, m_pcid, tk, tgt);
            #1;
            chk("rand taken_id", 32'(taken_id), 32'(tk));
            chk("rand pc8_id", pc8_id, m_pcid + 32'd8);
            if (rst) begin
                m_pc = 32'h3000; m_pcid = 32'h3000; m_instr = 32'h0; m_br = 32'h0; m_tk = 32'h0;
            end else if (!stl) begin
                if (op >= 4'd1 && op <= 4'd6) begin
                    m_br = m_br + 32'd1;
                    if (tk) m_tk = m_tk + 32'd1;
                end
                m_pcid  = m_pc;
                m_pc    = tk ? tgt : m_pc + 32'd4;
                m_instr = ins;
            end
            @(posedge clk);
            #1;
            chk("rand pc_if", pc_if, m_pc);
            chk("rand pc_id", pc_id, m_pcid);
            chk("rand instr_id", instr_id, m_instr);
`ifdef NPC_STATS_EN
            chk("rand br_cnt", br_cnt, m_br);
            chk("rand taken_cnt", taken_cnt, m_tk);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
